// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage: FSM state enum,
// IF/ID register layout, and the default reset PC and bubble instruction.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic                  valid;
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc4;
        logic [31:0]           instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Clear turns the slot into a bubble, load captures
// a new fetch, and hold (or no request) keeps the current contents.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   clear,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    // Clearing keeps the PC fields; only the valid bit and instruction become a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            q.valid <= 1'b0;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.instr <= NOP_INSTR;
        end else if (clear) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load && !hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage front end: program counter, boot/run/halt FSM and IF/ID capture.
// Optional build macro FETCH_MISALIGN_TRAP_EN halts on misaligned redirect targets.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int               XLEN      = FETCH_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0]      NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic [1:0]      fetch_state_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
`endif
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;
    logic            misaligned;
    logic            if_id_hold;
    logic            if_id_clear;
    logic            if_id_load;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign pc_plus4        = pc + {{(XLEN-3){1'b0}}, 3'd4};
    assign redirect_target = redirect_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (redirect_pc_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        if_id_hold  = 1'b0;
        if_id_clear = 1'b0;
        if_id_load  = 1'b0;
        if_id_d     = '{valid: 1'b1, pc: pc, pc4: pc_plus4, instr: imem_rdata_i};
        case (state)
            RUN: begin
                if (redirect_i || halt_i || flush_i) if_id_clear = 1'b1;
                else if (stall_i)                    if_id_hold  = 1'b1;
                else                                 if_id_load  = 1'b1;
            end
            HALTED:  if_id_clear = redirect_i;
            default: if_id_hold  = 1'b1;
        endcase
    end

    // PC and FSM share one register block so a redirect and its state change land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= BOOT;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (redirect_i) begin
                        if (misaligned) begin
                            state <= HALTED;
`ifdef FETCH_MISALIGN_TRAP_EN
                            misalign_o      <= 1'b1;
                            misalign_addr_o <= redirect_pc_i;
`endif
                        end else begin
                            pc <= redirect_target;
                        end
                    end else if (halt_i) begin
                        state <= HALTED;
                    end else if (!stall_i) begin
                        pc <= pc_plus4;
                    end
                end
                HALTED: begin
                    if (redirect_i) begin
                        if (misaligned) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                            misalign_o      <= 1'b1;
                            misalign_addr_o <= redirect_pc_i;
`endif
                        end else begin
                            pc    <= redirect_target;
                            state <= RUN;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk  (clk),
        .rst  (rst),
        .hold (if_id_hold),
        .clear(if_id_clear),
        .load (if_id_load),
        .d    (if_id_d),
        .q    (if_id_q)
    );

    assign imem_addr_o   = pc;
    assign fetch_state_o = state;
    assign if_id_valid_o = if_id_q.valid;
    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;

endmodule
